// File: rtl/dflow_replay_sequencer_if.sv
// dflow_replay_sequencer_if
//   Tuple write / read-return bus between the replay sequencer, the tuple
//   source, the QDR user interface and the downstream consumer.
//
//   Handshake semantics:
//     store: an entry moves when store_vld & store_rdy in the same cycle.
//            store_vld must not depend on store_rdy.
//     write: wr_cmd is a one-cycle strobe qualifying wr_addr.
//     read : rd_cmd is a one-cycle strobe qualifying rd_addr. Every rd_cmd
//            is answered later by one rd_valid pulse. out_ready=1 means
//            downstream can take one more return, and it gates new reads.
//
//   Modports:
//     master - the sequencer (drives store_rdy, wr_*, rd_cmd/rd_addr)
//     slave  - the environment (drives store_vld, out_ready, rd_valid)
interface dflow_replay_sequencer_if #(
    parameter int QDR_ADDR_WIDTH = 19
);
    logic                      store_vld;
    logic                      store_rdy;
    logic                      out_ready;
    logic                      wr_cmd;
    logic [QDR_ADDR_WIDTH-1:0] wr_addr;
    logic                      rd_cmd;
    logic [QDR_ADDR_WIDTH-1:0] rd_addr;
    logic                      rd_valid;

    modport master (
        input  store_vld, out_ready, rd_valid,
        output store_rdy, wr_cmd, wr_addr, rd_cmd, rd_addr
    );

    modport slave (
        output store_vld, out_ready, rd_valid,
        input  store_rdy, wr_cmd, wr_addr, rd_cmd, rd_addr
    );
endinterface

// File: rtl/dflow_replay_sequencer.sv
// dflow_replay_sequencer
//   Turns the software store/replay control levels into QDR write and read
//   commands over the window [mem_addr_low, mem_addr_high]. Stores tuples
//   until the window is full or start_store drops, then replays the stored
//   region replay_loops times (0 = until start_replay drops), bounding the
//   reads in flight to MAX_OUTSTANDING and honouring out_ready.
//
//   Ports:
//     clk, reset            qdr_clk domain clock, synchronous active-high reset
//     init_calib_complete   starts are ignored until QDR calibration is done
//     sw_rst                software reset level, same effect as reset
//     start_store/replay    enable levels; rising edges start an operation
//     mem_addr_low/high     address window (high inclusive)
//     replay_loops          passes over the stored region, 0 = unbounded
//     bus                   store handshake, QDR write/read commands, returns
//     compelete_store/replay, cfg_err   sticky status flags
//     stored_count          entries written by the last store
//     state                 FSM state (IDLE 0, STORE 1, REPLAY 2, DRAIN 3, DONE 4)
//     replay_count, loop_count  statistics, present only with DFLOW_SEQ_STATS_EN
//
//   Build option: define DFLOW_SEQ_STATS_EN to enable the statistics counters;
//   otherwise replay_count and loop_count are tied to zero.
module dflow_replay_sequencer #(
    parameter int QDR_ADDR_WIDTH  = 19,
    parameter int MAX_OUTSTANDING = 16,
    parameter int LOOP_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      init_calib_complete,
    input  logic                      sw_rst,
    input  logic                      start_store,
    input  logic                      start_replay,
    input  logic [QDR_ADDR_WIDTH-1:0] mem_addr_low,
    input  logic [QDR_ADDR_WIDTH-1:0] mem_addr_high,
    input  logic [LOOP_WIDTH-1:0]     replay_loops,
    dflow_replay_sequencer_if.master  bus,
    output logic                      compelete_store,
    output logic                      compelete_replay,
    output logic                      cfg_err,
    output logic [QDR_ADDR_WIDTH:0]   stored_count,
    output logic [2:0]                state,
    output logic [31:0]               replay_count,
    output logic [LOOP_WIDTH-1:0]     loop_count
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STORE  = 3'd1,
        ST_REPLAY = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t state_q, state_next;

    logic                      rst_all;
    logic                      store_lvl, replay_lvl, store_edge, replay_edge;
    logic [QDR_ADDR_WIDTH-1:0] wr_ptr, rd_ptr, wr_addr_q, rd_addr_q, last_addr;
    logic [QDR_ADDR_WIDTH:0]   stored_cnt;
    logic [LOOP_WIDTH-1:0]     loop_cnt;
    logic [CNT_W-1:0]          out_cnt, out_next;
    logic                      wr_cmd_q, rd_cmd_q;
    logic                      c_store_q, c_replay_q, cfg_err_q;
    logic                      store_go, replay_go, cfg_hit, accept, issue, wrap;
    logic                      set_store_done, set_replay_done;

    assign rst_all   = reset | sw_rst;
    // Last stored address; wraps correctly even for a full 2^W window.
    assign last_addr = mem_addr_low + stored_cnt[QDR_ADDR_WIDTH-1:0] - 1'b1;

    // Edge detectors. During reset the level registers track the inputs so
    // a level held high across a reset is not taken as a fresh start.
    always_ff @(posedge clk) begin
        store_lvl  <= start_store;
        replay_lvl <= start_replay;
        if (rst_all) begin
            store_edge  <= 1'b0;
            replay_edge <= 1'b0;
        end else begin
            store_edge  <= start_store & ~store_lvl;
            replay_edge <= start_replay & ~replay_lvl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_all) state_q <= ST_IDLE;
        else         state_q <= state_next;
    end

    always_comb begin
        state_next      = state_q;
        store_go        = 1'b0;
        replay_go       = 1'b0;
        cfg_hit         = 1'b0;
        accept          = 1'b0;
        issue           = 1'b0;
        wrap            = 1'b0;
        set_store_done  = 1'b0;
        set_replay_done = 1'b0;

        // Counter value after this cycle; a return in the same cycle as a
        // read cancels out, and a stray return at zero is dropped.
        out_next = out_cnt;
        if (rd_cmd_q && !bus.rd_valid)
            out_next = out_cnt + 1'b1;
        else if (!rd_cmd_q && bus.rd_valid && out_cnt != '0)
            out_next = out_cnt - 1'b1;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (init_calib_complete && (store_edge || replay_edge)) begin
                    if (mem_addr_high < mem_addr_low) begin
                        cfg_hit = 1'b1;
                    end else if (store_edge) begin
                        store_go   = 1'b1;
                        state_next = ST_STORE;
                    end else if (stored_cnt == '0) begin
                        // Nothing to replay: complete immediately.
                        set_replay_done = 1'b1;
                        state_next      = ST_DONE;
                    end else begin
                        replay_go  = 1'b1;
                        state_next = ST_REPLAY;
                    end
                end
            end
            ST_STORE: begin
                accept = bus.store_vld;
                if ((accept && wr_ptr == mem_addr_high) || !start_store) begin
                    set_store_done = 1'b1;
                    state_next     = ST_DONE;
                end
            end
            ST_REPLAY: begin
                if (!start_replay) begin
                    state_next = ST_DRAIN;
                end else if (bus.out_ready && out_next < MAX_CNT) begin
                    issue = 1'b1;
                    if (rd_ptr == last_addr) begin
                        wrap = 1'b1;
                        if (replay_loops != '0 && loop_cnt + 1'b1 == replay_loops)
                            state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_cnt == '0 && !rd_cmd_q) begin
                    set_replay_done = 1'b1;
                    state_next      = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_all) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            wr_cmd_q   <= 1'b0;
            rd_cmd_q   <= 1'b0;
            stored_cnt <= '0;
            loop_cnt   <= '0;
            out_cnt    <= '0;
            c_store_q  <= 1'b0;
            c_replay_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            wr_cmd_q <= accept;
            rd_cmd_q <= issue;
            out_cnt  <= out_next;
            if (accept) begin
                wr_addr_q  <= wr_ptr;
                wr_ptr     <= wr_ptr + 1'b1;
                stored_cnt <= stored_cnt + 1'b1;
            end
            if (issue) begin
                rd_addr_q <= rd_ptr;
                rd_ptr    <= wrap ? mem_addr_low : rd_ptr + 1'b1;
                if (wrap) loop_cnt <= loop_cnt + 1'b1;
            end
            if (cfg_hit) cfg_err_q <= 1'b1;
            if (store_go) begin
                c_store_q  <= 1'b0;
                c_replay_q <= 1'b0;
                stored_cnt <= '0;
                wr_ptr     <= mem_addr_low;
            end
            if (replay_go) begin
                c_replay_q <= 1'b0;
                loop_cnt   <= '0;
                out_cnt    <= '0;
                rd_ptr     <= mem_addr_low;
            end
            if (set_store_done)  c_store_q  <= 1'b1;
            if (set_replay_done) c_replay_q <= 1'b1;
        end
    end

    assign bus.store_rdy    = (state_q == ST_STORE);
    assign bus.wr_cmd       = wr_cmd_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.rd_cmd       = rd_cmd_q;
    assign bus.rd_addr      = rd_addr_q;
    assign compelete_store  = c_store_q;
    assign compelete_replay = c_replay_q;
    assign cfg_err          = cfg_err_q;
    assign stored_count     = stored_cnt;
    assign state            = state_q;

`ifdef DFLOW_SEQ_STATS_EN
    logic [31:0] replay_cnt_q;

    always_ff @(posedge clk) begin
        if (rst_all || replay_go)
            replay_cnt_q <= '0;
        else if (rd_cmd_q && replay_cnt_q != '1)
            replay_cnt_q <= replay_cnt_q + 1'b1;
    end

    assign replay_count = replay_cnt_q;
    assign loop_count   = loop_cnt;
`else
    assign replay_count = '0;
    assign loop_count   = '0;
`endif
endmodule

// File: tb/tb_dflow_replay_sequencer.sv
// tb_dflow_replay_sequencer
//   Directed bench for dflow_replay_sequencer: store windows, bounded replay
//   with delayed returns, outstanding-read limit, start arbitration, window
//   errors and software reset.
module tb_dflow_replay_sequencer;
    localparam int AW = 19;
    localparam int LW = 16;

    logic          clk;
    logic          reset;
    logic          init_calib_complete;
    logic          sw_rst;
    logic          start_store;
    logic          start_replay;
    logic [AW-1:0] mem_addr_low;
    logic [AW-1:0] mem_addr_high;
    logic [LW-1:0] replay_loops;
    logic          compelete_store;
    logic          compelete_replay;
    logic          cfg_err;
    logic [AW:0]   stored_count;
    logic [2:0]    state;
    logic [31:0]   replay_count;
    logic [LW-1:0] loop_count;

    dflow_replay_sequencer_if #(.QDR_ADDR_WIDTH(AW)) bus_if ();

    dflow_replay_sequencer #(
        .QDR_ADDR_WIDTH (AW),
        .MAX_OUTSTANDING(16),
        .LOOP_WIDTH     (LW)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .init_calib_complete(init_calib_complete),
        .sw_rst             (sw_rst),
        .start_store        (start_store),
        .start_replay       (start_replay),
        .mem_addr_low       (mem_addr_low),
        .mem_addr_high      (mem_addr_high),
        .replay_loops       (replay_loops),
        .bus                (bus_if),
        .compelete_store    (compelete_store),
        .compelete_replay   (compelete_replay),
        .cfg_err            (cfg_err),
        .stored_count       (stored_count),
        .state              (state),
        .replay_count       (replay_count),
        .loop_count         (loop_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int            n_checks = 0;
    int            n_errors = 0;
    int            n_ret    = 0;
    logic [AW-1:0] wr_log[$];
    logic [AW-1:0] rd_log[$];
    logic [AW-1:0] exp_q[$];
    logic          resp_en;
    logic [4:0]    pipe;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: logs issued commands and returns away from the clock edge.
    initial begin
        forever begin
            @(negedge clk);
            if (bus_if.wr_cmd) wr_log.push_back(bus_if.wr_addr);
            if (bus_if.rd_cmd) rd_log.push_back(bus_if.rd_addr);
            if (bus_if.rd_valid) n_ret++;
            if (bus_if.wr_cmd && bus_if.rd_cmd) check("wr_rd_same_cycle", 32'd1, 32'd0);
        end
    end

    // ---------------- driver tasks ----------------
    // Advance one cycle; when enabled, answer each read four cycles later.
    task automatic tick();
        @(posedge clk);
        #1;
        pipe = {pipe[3:0], bus_if.rd_cmd};
        if (resp_en) bus_if.rd_valid = pipe[4];
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
        int n = 0;
        while (state !== target && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(state), 32'(target));
    endtask

    task automatic check_wr(input string tag);
        check({tag, "_n"}, 32'(wr_log.size()), 32'(exp_q.size()));
        foreach (exp_q[i])
            if (i < wr_log.size()) check($sformatf("%s_%0d", tag, i), 32'(wr_log[i]), 32'(exp_q[i]));
    endtask

    task automatic check_rd(input string tag);
        check({tag, "_n"}, 32'(rd_log.size()), 32'(exp_q.size()));
        foreach (exp_q[i])
            if (i < rd_log.size()) check($sformatf("%s_%0d", tag, i), 32'(rd_log[i]), 32'(exp_q[i]));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; sw_rst = 1'b0; init_calib_complete = 1'b1;
        start_store = 1'b0; start_replay = 1'b0;
        mem_addr_low = '0; mem_addr_high = '0; replay_loops = '0;
        bus_if.store_vld = 1'b0; bus_if.out_ready = 1'b0; bus_if.rd_valid = 1'b0;
        resp_en = 1'b0; pipe = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_state", 32'(state), 32'd0);
        check("rst_store_rdy", 32'(bus_if.store_rdy), 32'd0);
        check("rst_wr_cmd", 32'(bus_if.wr_cmd), 32'd0);
        check("rst_rd_cmd", 32'(bus_if.rd_cmd), 32'd0);
        check("rst_flags", 32'({compelete_store, compelete_replay, cfg_err}), 32'd0);
        check("rst_stored", 32'(stored_count), 32'd0);

        // Store 5 pulses into window 0x10..0x1F, then drop start_store
        mem_addr_low = 19'h10; mem_addr_high = 19'h1F;
        start_store = 1'b1;
        check("st1_edge_n0", 32'(state), 32'd0);
        tick();
        check("st1_edge_n1", 32'(state), 32'd0);
        tick();
        check("st1_edge_n2", 32'(state), 32'd1);
        check("st1_rdy", 32'(bus_if.store_rdy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            bus_if.store_vld = 1'b1; tick();
            bus_if.store_vld = 1'b0; tick();
        end
        start_store = 1'b0;
        wait_state(3'd4, 5, "st1_done");
        tick();
        exp_q = '{19'h10, 19'h11, 19'h12, 19'h13, 19'h14};
        check_wr("st1_wr");
        check("st1_stored", 32'(stored_count), 32'd5);
        check("st1_cstore", 32'(compelete_store), 32'd1);
        check("st1_rdy_done", 32'(bus_if.store_rdy), 32'd0);

        // Continuous store into 0x0..0x3: window-full exit
        wr_log.delete();
        mem_addr_low = 19'h0; mem_addr_high = 19'h3;
        start_store = 1'b1; bus_if.store_vld = 1'b1;
        wait_state(3'd1, 5, "st2_store");
        wait_state(3'd4, 10, "st2_done");
        repeat (3) tick();
        exp_q = '{19'h0, 19'h1, 19'h2, 19'h3};
        check_wr("st2_wr");
        check("st2_stored", 32'(stored_count), 32'd4);
        check("st2_rdy", 32'(bus_if.store_rdy), 32'd0);
        bus_if.store_vld = 1'b0; start_store = 1'b0;
        tick();

        // Store 3 entries at 0x10, replay 2 loops with 4-cycle returns
        wr_log.delete();
        mem_addr_low = 19'h10; mem_addr_high = 19'h1F;
        start_store = 1'b1;
        wait_state(3'd1, 5, "rp_store");
        bus_if.store_vld = 1'b1;
        repeat (3) tick();
        bus_if.store_vld = 1'b0; start_store = 1'b0;
        wait_state(3'd4, 5, "rp_store_done");
        check("rp_stored", 32'(stored_count), 32'd3);
        rd_log.delete(); n_ret = 0;
        replay_loops = 16'd2; bus_if.out_ready = 1'b1; resp_en = 1'b1;
        start_replay = 1'b1;
        wait_state(3'd2, 5, "rp_replay");
        wait_state(3'd3, 40, "rp_drain");
        check("rp_drain_crep", 32'(compelete_replay), 32'd0);
        wait_state(3'd4, 40, "rp_done");
        check("rp_crep", 32'(compelete_replay), 32'd1);
        check("rp_returns", 32'(n_ret), 32'd6);
        exp_q = '{19'h10, 19'h11, 19'h12, 19'h10, 19'h11, 19'h12};
        check_rd("rp_rd");
        start_replay = 1'b0; resp_en = 1'b0; bus_if.rd_valid = 1'b0;
        tick();

        // Outstanding limit: returns withheld, unbounded loops
        rd_log.delete();
        replay_loops = 16'd0;
        start_replay = 1'b1;
        wait_state(3'd2, 5, "lim_replay");
        repeat (30) tick();
        check("lim_reads", 32'(rd_log.size()), 32'd16);
        if (rd_log.size() == 16) check("lim_last_addr", 32'(rd_log[15]), 32'h10);
        check("lim_stall", 32'(bus_if.rd_cmd), 32'd0);
        bus_if.rd_valid = 1'b1;
        check("rel_v0", 32'(bus_if.rd_cmd), 32'd0);
        tick();
        check("rel_v1", 32'(bus_if.rd_cmd), 32'd1);
        tick();
        bus_if.rd_valid = 1'b0;
        check("rel_same_cycle", 32'(bus_if.rd_cmd), 32'd1);
        tick();
        check("rel_v3", 32'(bus_if.rd_cmd), 32'd0);
        tick();
        check("rel_reads", 32'(rd_log.size()), 32'd18);
`ifndef DFLOW_SEQ_STATS_EN
        check("stats_tied", replay_count | 32'(loop_count), 32'd0);
`endif

        // Software reset mid-REPLAY
        check("sw_pre_state", 32'(state), 32'd2);
        sw_rst = 1'b1;
        tick();
        check("sw_state", 32'(state), 32'd0);
        check("sw_rd_cmd", 32'(bus_if.rd_cmd), 32'd0);
        check("sw_flags", 32'({compelete_store, compelete_replay, cfg_err}), 32'd0);
        check("sw_stored", 32'(stored_count), 32'd0);
        sw_rst = 1'b0; start_replay = 1'b0;
        tick();
        rd_log.delete();
        start_replay = 1'b1;
        tick();
        tick();
        check("sw_empty_replay_state", 32'(state), 32'd4);
        check("sw_empty_replay_crep", 32'(compelete_replay), 32'd1);
        tick();
        check("sw_empty_replay_reads", 32'(rd_log.size()), 32'd0);

        // Same-cycle store and replay edges: store wins
        start_replay = 1'b0;
        tick();
        mem_addr_low = 19'h0; mem_addr_high = 19'h7;
        start_store = 1'b1; start_replay = 1'b1;
        tick();
        tick();
        check("both_state", 32'(state), 32'd1);
        check("both_crep_cleared", 32'(compelete_replay), 32'd0);
        start_store = 1'b0; start_replay = 1'b0;
        wait_state(3'd4, 5, "both_done");

        // Inverted window: cfg_err, state unchanged
        mem_addr_low = 19'h9; mem_addr_high = 19'h5;
        start_store = 1'b1;
        repeat (3) tick();
        check("cfg_state", 32'(state), 32'd4);
        check("cfg_err", 32'(cfg_err), 32'd1);
        start_store = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end
endmodule
